// File: rtl/crc16_pkg.sv
// Shared constants, FSM state type and the single-bit CRC step for the CRC16 frame checker.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_t;

    // MSB-first, non-reflected LFSR advance by one message bit
    function automatic logic [15:0] crc16_step(input logic [15:0] cur,
                                               input logic        bit_in,
                                               input logic [15:0] poly);
        logic fb;
        fb = cur[15] ^ bit_in;
        return {cur[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_frame_ctrl_if.sv
// Byte-input and CRC-result handshake bundle for crc16_frame_ctrl.
interface crc16_frame_ctrl_if;

    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        abort;
    logic        crc_valid;
    logic [15:0] crc_value;
    logic        crc_ok;
    logic        crc_ready;
    logic [15:0] frame_len;
    logic        busy;

    modport master (
        output s_valid, s_data, s_last, abort, crc_ready,
        input  s_ready, crc_valid, crc_value, crc_ok, frame_len, busy
    );

    modport slave (
        input  s_valid, s_data, s_last, abort, crc_ready,
        output s_ready, crc_valid, crc_value, crc_ok, frame_len, busy
    );

endinterface

// File: rtl/crc16_lfsr_bit.sv
// Bit-serial CRC16 LFSR: load has priority over en; one message bit per enabled cycle.
module crc16_lfsr_bit
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY,
    parameter logic [15:0] INIT = CRC16_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= INIT;
        end else if (load) begin
            lfsr <= init;
        end else if (en) begin
            lfsr <= crc16_step(lfsr, bit_in, POLY);
        end
    end

endmodule

// File: rtl/crc16_frame_ctrl.sv
// Frame sequencer for a bit-serial CRC16: accepts bytes, shifts them MSB-first,
// and presents the result with crc_ok once the last byte has been consumed.
module crc16_frame_ctrl
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY,
    parameter logic [15:0] INIT = CRC16_INIT
) (
    input  logic                clk,
    input  logic                rst,
    crc16_frame_ctrl_if.slave   bus
);

    crc_state_t  state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  data_q;
    logic        last_q;
    logic        started_q;
    logic [15:0] frame_len_q;
    logic [15:0] lfsr;

    logic        s_ready;
    logic        accept;
    logic        shift_en;
    logic        lfsr_load;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d  = state_q;
        s_ready  = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready = !bus.abort;
            end
            ST_SHIFT: begin
                shift_en = !bus.abort;
                if (bit_cnt_q == 3'd0) begin
                    if (!last_q) begin
                        // Next byte may be taken on the same edge as the final bit: no bubble
                        s_ready = !bus.abort;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.crc_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        accept    = bus.s_valid && s_ready;
        lfsr_load = accept && !started_q;
        if (accept)    state_d = ST_SHIFT;
        if (bus.abort) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            last_q      <= 1'b0;
            started_q   <= 1'b0;
            frame_len_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (bus.abort || state_q == ST_DONE) begin
                started_q <= 1'b0;
            end else if (accept) begin
                started_q <= 1'b1;
            end
            if (accept) begin
                last_q      <= bus.s_last;
                bit_cnt_q   <= 3'd7;
                frame_len_q <= started_q ? sat_inc16(frame_len_q) : 16'd1;
            end else if (shift_en && bit_cnt_q != 3'd0) begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
            end
        end
    end

    // Byte payload carries no control meaning, so it is left out of reset
    always_ff @(posedge clk) begin
        if (accept) data_q <= bus.s_data;
    end

    crc16_lfsr_bit #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .init   (INIT),
        .en     (shift_en),
        .bit_in (data_q[bit_cnt_q]),
        .lfsr   (lfsr)
    );

    assign bus.s_ready   = s_ready;
    assign bus.crc_valid = (state_q == ST_DONE);
    assign bus.crc_value = lfsr;
    assign bus.crc_ok    = (lfsr == 16'h0000);
    assign bus.frame_len = frame_len_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Directed bench for crc16_frame_ctrl: known CRC16/BUYPASS vectors, latency, back-pressure,
// abort/reset mid-frame and inter-byte gaps.
module tb_crc16_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0 = 0;

    logic [7:0] msg [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc16_frame_ctrl_if bus ();

    crc16_frame_ctrl #(
        .POLY (16'h8005),
        .INIT (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        bus.s_data  = b;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (bus.s_ready) break;
            step();
        end
        chk("s_ready_wait", {31'd0, bus.s_ready}, 32'd1);
        step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int gap_after, input int gap_len, input bit with_crc);
        for (int i = 0; i < 9; i++) begin
            send_byte(msg[i], (i == 8) && !with_crc);
            if (i == 0) t0 = cyc;
            if (i == gap_after) repeat (7 + gap_len) step();
        end
        if (with_crc) begin
            send_byte(8'hFE, 1'b0);
            send_byte(8'hE8, 1'b1);
        end
    endtask

    task automatic wait_done(input int exp_lat, input logic [15:0] exp_crc,
                             input logic exp_ok, input logic [15:0] exp_len);
        for (int i = 0; i < 120; i++) begin
            if (bus.crc_valid) break;
            step();
        end
        chk("crc_valid", {31'd0, bus.crc_valid}, 32'd1);
        chk("latency", cyc - t0, exp_lat);
        chk("crc_value", {16'd0, bus.crc_value}, {16'd0, exp_crc});
        chk("crc_ok", {31'd0, bus.crc_ok}, {31'd0, exp_ok});
        chk("frame_len", {16'd0, bus.frame_len}, {16'd0, exp_len});
        chk("s_ready_done", {31'd0, bus.s_ready}, 32'd0);
        chk("busy_done", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic release_result();
        bus.crc_ready = 1'b1;
        step();
        bus.crc_ready = 1'b0;
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_crc_valid", {31'd0, bus.crc_valid}, 32'd0);
    endtask

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_data    = 8'h00;
        bus.s_last    = 1'b0;
        bus.abort     = 1'b0;
        bus.crc_ready = 1'b0;

        // Reset
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("rst_crc_valid", {31'd0, bus.crc_valid}, 32'd0);
        chk("rst_crc_value", {16'd0, bus.crc_value}, 32'd0);
        chk("rst_crc_ok", {31'd0, bus.crc_ok}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_frame_len", {16'd0, bus.frame_len}, 32'd0);

        // "123456789" with 20 cycles of back-pressure in DONE
        send_frame(-1, 0, 1'b0);
        wait_done(72, 16'hFEE8, 1'b0, 16'd9);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_valid", {31'd0, bus.crc_valid}, 32'd1);
            chk("hold_value", {16'd0, bus.crc_value}, 32'h0000FEE8);
            chk("hold_s_ready", {31'd0, bus.s_ready}, 32'd0);
        end
        release_result();
        chk("idle_frame_len", {16'd0, bus.frame_len}, 32'd9);
        chk("idle_s_ready", {31'd0, bus.s_ready}, 32'd1);

        // Second frame must restart from INIT
        send_frame(-1, 0, 1'b0);
        wait_done(72, 16'hFEE8, 1'b0, 16'd9);
        release_result();

        // Single-byte frames
        send_byte(8'h01, 1'b1);
        t0 = cyc;
        wait_done(8, 16'h8005, 1'b0, 16'd1);
        release_result();
        send_byte(8'h00, 1'b1);
        t0 = cyc;
        wait_done(8, 16'h0000, 1'b1, 16'd1);
        release_result();

        // Message followed by its own CRC gives a zero residue
        send_frame(-1, 0, 1'b1);
        wait_done(88, 16'h0000, 1'b1, 16'd11);
        release_result();

        // Abort at bit_cnt=3 of byte 2, with a byte offered in the abort cycle
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        repeat (4) step();
        bus.abort   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h33;
        chk("abort_s_ready", {31'd0, bus.s_ready}, 32'd0);
        step();
        bus.abort   = 1'b0;
        bus.s_valid = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        repeat (12) step();
        chk("abort_no_valid", {31'd0, bus.crc_valid}, 32'd0);
        chk("abort_idle", {31'd0, bus.busy}, 32'd0);
        send_frame(-1, 0, 1'b0);
        wait_done(72, 16'hFEE8, 1'b0, 16'd9);
        release_result();

        // Same interruption using a reset pulse
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        repeat (4) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rstp_busy", {31'd0, bus.busy}, 32'd0);
        chk("rstp_crc_value", {16'd0, bus.crc_value}, 32'd0);
        chk("rstp_frame_len", {16'd0, bus.frame_len}, 32'd0);
        repeat (12) step();
        chk("rstp_no_valid", {31'd0, bus.crc_valid}, 32'd0);
        send_frame(-1, 0, 1'b0);
        wait_done(72, 16'hFEE8, 1'b0, 16'd9);
        release_result();

        // Five-cycle gap between bytes 4 and 5
        send_frame(3, 5, 1'b0);
        wait_done(77, 16'hFEE8, 1'b0, 16'd9);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
